// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and line idle level.
// The tx side imports the same idle level so both directions agree on it.
package uart_pkg;

    typedef enum logic [2:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_PARITY,
        UART_STOP
    } uart_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin.
// Reset presets both flops to the idle line level so no false start bit appears.
module rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= UART_IDLE_LEVEL;
            q    <= UART_IDLE_LEVEL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: centre-samples start, 8 data bits LSB-first, optional parity
// and stop, then strobes the byte with its parity/framing status for one cycle.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter bit PARITY_EN    = 1'b1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       framing_error,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

    uart_state_t               state_q;
    uart_state_t               state_d;
    logic                      rx_s;
    logic                      sample_now;
    logic                      deliver;
    logic [CNT_W-1:0]          baud_cnt;
    logic [IDX_W-1:0]          bit_idx;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic                      parity_bad;
    logic                      stop_bit;
    logic                      stop_seen;

    rx_sync u_rx_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rx),
        .q    (rx_s)
    );

    assign busy = (state_q != UART_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UART_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // STOP spends one extra cycle after its sample so the strobe lands on the next edge
    always_comb begin
        state_d    = state_q;
        sample_now = 1'b0;
        deliver    = 1'b0;
        case (state_q)
            UART_IDLE: begin
                if (rx_s != UART_IDLE_LEVEL) begin
                    state_d = UART_START;
                end
            end
            UART_START: begin
                if (baud_cnt == HALF_LAST) begin
                    sample_now = 1'b1;
                    state_d    = (rx_s == UART_IDLE_LEVEL) ? UART_IDLE : UART_DATA;
                end
            end
            UART_DATA: begin
                if (baud_cnt == FULL_LAST) begin
                    sample_now = 1'b1;
                    if (bit_idx == IDX_LAST) begin
                        state_d = PARITY_EN ? UART_PARITY : UART_STOP;
                    end
                end
            end
            UART_PARITY: begin
                if (baud_cnt == FULL_LAST) begin
                    sample_now = 1'b1;
                    state_d    = UART_STOP;
                end
            end
            UART_STOP: begin
                if (stop_seen) begin
                    deliver = 1'b1;
                    state_d = UART_IDLE;
                end else if (baud_cnt == FULL_LAST) begin
                    sample_now = 1'b1;
                end
            end
            default: begin
                state_d = UART_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt      <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            parity_bad    <= 1'b0;
            stop_bit      <= 1'b0;
            stop_seen     <= 1'b0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            if (state_q == UART_IDLE || sample_now || deliver) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + CNT_W'(1);
            end
            case (state_q)
                UART_IDLE: begin
                    bit_idx    <= '0;
                    parity_bad <= 1'b0;
                    stop_seen  <= 1'b0;
                end
                UART_DATA: begin
                    if (sample_now) begin
                        shift_reg <= {rx_s, shift_reg[UART_DATA_BITS-1:1]};
                        bit_idx   <= bit_idx + IDX_W'(1);
                    end
                end
                UART_PARITY: begin
                    if (sample_now) begin
                        parity_bad <= ((^shift_reg) ^ rx_s) != PARITY_ODD;
                    end
                end
                UART_STOP: begin
                    if (deliver) begin
                        data_out      <= shift_reg;
                        data_valid    <= 1'b1;
                        parity_error  <= PARITY_EN && parity_bad;
                        framing_error <= ~stop_bit;
                        stop_seen     <= 1'b0;
                    end else if (sample_now) begin
                        stop_bit  <= rx_s;
                        stop_seen <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised and directed bench for uart_rx: three receivers (even parity, odd parity,
// no parity) are compared against a frame-level reference model of strobe time and content.
module tb_uart_rx;

    localparam int CPB = 4;

    typedef struct packed {
        int         dut;
        int         t;
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       busy;
    } strobe_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic rx_p  = 1'b1;
    logic rx_n  = 1'b1;

    logic [7:0] do_e, do_o, do_n;
    logic       dv_e, dv_o, dv_n;
    logic       pe_e, pe_o, pe_n;
    logic       fe_e, fe_o, fe_n;
    logic       busy_e, busy_o, busy_n;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [7:0] last_data [3];
    strobe_t obs_q[$];
    strobe_t exp_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_even (
        .clk(clk), .rst_n(rst_n), .rx(rx_p), .data_out(do_e), .data_valid(dv_e),
        .parity_error(pe_e), .framing_error(fe_e), .busy(busy_e)
    );

    uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .rx(rx_p), .data_out(do_o), .data_valid(dv_o),
        .parity_error(pe_o), .framing_error(fe_o), .busy(busy_o)
    );

    uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_nopar (
        .clk(clk), .rst_n(rst_n), .rx(rx_n), .data_out(do_n), .data_valid(dv_n),
        .parity_error(pe_n), .framing_error(fe_n), .busy(busy_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] dut_outputs(input int d);
        case (d)
            0:       return {do_e, dv_e, pe_e, fe_e, busy_e};
            1:       return {do_o, dv_o, pe_o, fe_o, busy_o};
            default: return {do_n, dv_n, pe_n, fe_n, busy_n};
        endcase
    endfunction

    // Capture every strobe with the clock edge number at which it became visible
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            logic [11:0] v;
            strobe_t     s;
            v = dut_outputs(d);
            if (v[3]) begin
                s.dut  = d;
                s.t    = cyc;
                s.data = v[11:4];
                s.pe   = v[2];
                s.fe   = v[1];
                s.busy = v[0];
                obs_q.push_back(s);
            end
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model: a frame whose start is first read low at edge t0 strobes once,
    // one edge after its last bit centre at t0 + 2 + CPB/2 + k*CPB
    task automatic expect_frame(input int d, input int t0, input logic [7:0] data,
                                input logic pbit, input logic stop);
        strobe_t s;
        int      nbits;
        int      ones;
        nbits  = (d == 2) ? 10 : 11;
        ones   = $countones(data) + int'(pbit);
        s.dut  = d;
        s.t    = t0 + 2 + CPB / 2 + (nbits - 1) * CPB + 1;
        s.data = data;
        s.pe   = (d == 2) ? 1'b0 : ((ones % 2) != ((d == 1) ? 1 : 0));
        s.fe   = !stop;
        s.busy = 1'b0;
        exp_q.push_back(s);
        last_data[d] = data;
    endtask

    task automatic idle_line(input int n);
        rx_p = 1'b1;
        rx_n = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame from a negedge; abort_bit >= 0 pulses reset at that bit instead
    task automatic applyStimulus(input int line, input logic [7:0] data, input logic pbit,
                                 input logic stop, input int abort_bit, output int t0);
        logic [10:0] frame;
        int          nb;
        nb    = (line == 0) ? 11 : 10;
        frame = (line == 0) ? {stop, pbit, data, 1'b0} : {1'b0, stop, data, 1'b0};
        t0    = cyc + 1;
        for (int k = 0; k < nb; k++) begin
            if (k == abort_bit) begin
                rst_n = 1'b0;
                rx_p  = 1'b1;
                rx_n  = 1'b1;
                for (int d = 0; d < 3; d++) last_data[d] = 8'h00;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (line == 0) rx_p = frame[k];
            else           rx_n = frame[k];
            repeat (CPB) @(negedge clk);
        end
        if (line == 0) begin
            expect_frame(0, t0, data, pbit, stop);
            expect_frame(1, t0, data, pbit, stop);
        end else begin
            expect_frame(2, t0, data, pbit, stop);
        end
    endtask

    task automatic checkStrobes(input string tag);
        for (int d = 0; d < 3; d++) begin
            strobe_t     o[$];
            strobe_t     e[$];
            logic [11:0] v;
            o.delete();
            e.delete();
            foreach (obs_q[i]) if (obs_q[i].dut == d) o.push_back(obs_q[i]);
            foreach (exp_q[i]) if (exp_q[i].dut == d) e.push_back(exp_q[i]);
            checkOutput($sformatf("%s_d%0d_count", tag, d), o.size(), e.size());
            for (int i = 0; i < e.size() && i < o.size(); i++) begin
                checkOutput($sformatf("%s_d%0d_f%0d_time", tag, d, i), o[i].t, e[i].t);
                checkOutput($sformatf("%s_d%0d_f%0d_data", tag, d, i), o[i].data, e[i].data);
                checkOutput($sformatf("%s_d%0d_f%0d_perr", tag, d, i), o[i].pe, e[i].pe);
                checkOutput($sformatf("%s_d%0d_f%0d_ferr", tag, d, i), o[i].fe, e[i].fe);
                checkOutput($sformatf("%s_d%0d_f%0d_busy", tag, d, i), o[i].busy, e[i].busy);
            end
            v = dut_outputs(d);
            checkOutput($sformatf("%s_d%0d_hold", tag, d), v[11:4], last_data[d]);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int          t0;
        logic [11:0] v;
        logic [7:0]  data;
        logic        pbit;
        logic        stop;

        for (int d = 0; d < 3; d++) last_data[d] = 8'h00;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) checkOutput($sformatf("reset_d%0d", d), dut_outputs(d), 0);
        rst_n = 1'b1;
        idle_line(4);

        applyStimulus(0, 8'hA5, 1'b0, 1'b1, -1, t0);
        checkOutput("a5_busy_mid", busy_e, 1);
        idle_line(8);
        checkStrobes("a5");

        applyStimulus(0, 8'hFF, 1'b0, 1'b1, 5, t0);
        for (int d = 0; d < 3; d++) checkOutput($sformatf("abort_d%0d", d), dut_outputs(d), 0);
        idle_line(50);
        checkStrobes("abort");

        applyStimulus(0, 8'h12, 1'b0, 1'b1, -1, t0);
        idle_line(8);
        checkStrobes("after_abort");

        applyStimulus(0, 8'h01, 1'b0, 1'b1, -1, t0);
        idle_line(8);
        checkStrobes("parity");

        applyStimulus(0, 8'h3C, 1'b0, 1'b0, -1, t0);
        repeat (2 * 11 * CPB) @(negedge clk);
        for (int n = 1; n <= 2; n++) begin
            expect_frame(0, t0 + n * 11 * CPB, 8'h00, 1'b0, 1'b0);
            expect_frame(1, t0 + n * 11 * CPB, 8'h00, 1'b0, 1'b0);
        end
        idle_line(10);
        checkStrobes("break");

        t0   = cyc + 1;
        rx_p = 1'b0;
        @(negedge clk);
        rx_p = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("glitch_busy_up", busy_e, 1);
        repeat (3) @(negedge clk);
        checkOutput("glitch_busy_down_even", busy_e, 0);
        checkOutput("glitch_busy_down_odd", busy_o, 0);
        idle_line(50);
        checkStrobes("glitch");

        applyStimulus(1, 8'h55, 1'b0, 1'b1, -1, t0);
        applyStimulus(1, 8'hAA, 1'b0, 1'b1, -1, t0);
        idle_line(8);
        checkStrobes("b2b");

        for (int i = 0; i < 30; i++) begin
            data = 8'($urandom_range(0, 255));
            pbit = (^data) ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 7) != 0);
            applyStimulus(0, data, pbit, stop, -1, t0);
            idle_line($urandom_range(0, 3));
        end
        idle_line(10);
        checkStrobes("rand_par");

        for (int i = 0; i < 20; i++) begin
            data = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 7) != 0);
            applyStimulus(1, data, 1'b0, stop, -1, t0);
            idle_line($urandom_range(0, 3));
        end
        idle_line(10);
        checkStrobes("rand_nopar");

        v = dut_outputs(0);
        checkOutput("final_idle_busy", v[0], 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
